// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with a two-flop input synchroniser, start-glitch
// rejection, framing/overrun pulses and a single-entry ready/valid holding register.
module uart_rx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_rx,
  output logic       io_out_valid,
  input  logic       io_out_ready,
  output logic [7:0] io_out_bits,
  output logic       io_frame_err,
  output logic       io_overrun,
  output logic       io_busy
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DIV_M1  = cnt_t'(DIV - 1);
  localparam cnt_t HALF_M1 = cnt_t'(HALF - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: CLK_HZ / BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state, state_n;
  cnt_t        cnt, cnt_n;
  logic [2:0]  bitidx, bitidx_n;
  logic [7:0]  shift, shift_n;
  logic        rx_meta, rx_s;
  logic        stop_ok, stop_bad;
  logic        drain, load;
  logic        valid_n, overrun_n;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + cnt_t'(1);
    bitidx_n = bitidx;
    shift_n  = shift;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n  = DATA;
            bitidx_n = 3'd0;
          end
        end
      end
      DATA: begin
        if (cnt == DIV_M1) begin
          cnt_n          = '0;
          shift_n[bitidx] = rx_s;
          if (bitidx == 3'd7) state_n = STOP;
          else                bitidx_n = bitidx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == DIV_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_n = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must not be re-read as a stream of 0x00 frames.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // A byte may load into the holding register when it is empty or being
  // drained in this same cycle; otherwise the new byte is dropped.
  always_comb begin
    drain     = io_out_valid & io_out_ready;
    load      = stop_ok & (~io_out_valid | io_out_ready);
    overrun_n = stop_ok & io_out_valid & ~io_out_ready;
    valid_n   = io_out_valid;
    if (drain) valid_n = 1'b0;
    if (load)  valid_n = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bitidx       <= 3'd0;
      shift        <= 8'h00;
      io_out_valid <= 1'b0;
      io_out_bits  <= 8'h00;
      io_frame_err <= 1'b0;
      io_overrun   <= 1'b0;
    end else begin
      rx_meta      <= io_rx;
      rx_s         <= rx_meta;
      state        <= state_n;
      cnt          <= cnt_n;
      bitidx       <= bitidx_n;
      shift        <= shift_n;
      io_out_valid <= valid_n;
      if (load) io_out_bits <= shift_n;
      io_frame_err <= stop_bad;
      io_overrun   <= overrun_n;
    end
  end

  assign io_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: stimulus pushes expected bytes and
// flag counts, a negedge monitor pops and compares on every accepted byte.
module tb_uart_rx;

  localparam int CLK_HZ = 1700000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;   // 17
  localparam int HALF   = DIV / 2;         // 8

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_rx = 1'b1;
  logic       io_out_ready = 1'b1;
  logic       io_out_valid;
  logic [7:0] io_out_bits;
  logic       io_frame_err;
  logic       io_overrun;
  logic       io_busy;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_rx        (io_rx),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_frame_err (io_frame_err),
    .io_overrun   (io_overrun),
    .io_busy      (io_busy)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_ovr = 0;
  int seen_ferr = 0, seen_ovr = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic hs_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: scoreboard pop on every accepted byte, flag pulse counting.
  always @(negedge clock) begin
    if (reset) begin
      hs_prev    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (io_frame_err) seen_ferr++;
      if (io_overrun)   seen_ovr++;
      if (io_out_valid && !prev_valid) rise_cyc = cyc;
      if (hs_prev) check("valid_drop_after_accept", io_out_valid, 1'b0);
      if (io_out_valid && io_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h expected none (cycle %0d)", io_out_bits, cyc);
        end else begin
          check("rx_byte", io_out_bits, exp_q.pop_front());
        end
      end
      hs_prev    = io_out_valid && io_out_ready;
      prev_valid = io_out_valid;
    end
  end

  // Line driver; always entered and left one time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    io_rx = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive(b[i], DIV);
    drive(stop, DIV);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err_count"}, seen_ferr, exp_ferr);
    check({tag, "_overrun_count"}, seen_ovr, exp_ovr);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int start_cyc;
    int bc;
    logic [7:0] b;
    logic bad;
    int gap;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", io_out_valid, 1'b0);
    check("reset_bits", io_out_bits, 8'h00);
    check("reset_busy", io_busy, 1'b0);
    check("reset_flags", {io_frame_err, io_overrun}, 2'b00);
    reset = 1'b0;
    drive(1'b1, 4);

    // Single byte with latency measurement
    exp_q.push_back(8'h55);
    rise_cyc  = -1;
    start_cyc = cyc;
    send_frame(8'h55, 1'b1);
    drive(1'b1, DIV);
    check("single_latency", rise_cyc - start_cyc, 3 + HALF + 9 * DIV);
    check_flags("single");

    // Back-to-back frames, zero idle gap
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    drive(1'b1, 2 * DIV);
    check_flags("b2b");

    // Backpressure: second byte overruns the full holding register
    io_out_ready = 1'b0;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    exp_ovr++;
    drive(1'b1, 2 * DIV);
    check("ovr_valid_held", io_out_valid, 1'b1);
    check("ovr_bits_held", io_out_bits, 8'h12);
    check("ovr_pulse_count", seen_ovr, exp_ovr);
    io_out_ready = 1'b1;
    drive(1'b1, 3);
    check("ovr_valid_cleared", io_out_valid, 1'b0);
    check_flags("ovr");

    // Framing error followed by a break
    send_frame(8'h3C, 1'b0);
    exp_ferr++;
    drive(1'b0, 2 * DIV);
    check("break_busy_early", io_busy, 1'b1);
    check("break_ferr_count", seen_ferr, exp_ferr);
    drive(1'b0, 3 * DIV);
    check("break_busy_late", io_busy, 1'b1);
    check("break_no_valid", io_out_valid, 1'b0);
    drive(1'b1, 4);
    check("break_busy_released", io_busy, 1'b0);
    drive(1'b1, DIV);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    drive(1'b1, DIV);
    check_flags("break");

    // Start-bit glitch shorter than half a bit
    bc = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      io_rx = (i < 3) ? 1'b0 : 1'b1;
      @(posedge clock);
      #1;
      if (io_busy) bc++;
    end
    check("glitch_busy_window", (bc >= HALF) && (bc <= HALF + 2), 1'b1);
    check("glitch_idle_after", io_busy, 1'b0);
    check_flags("glitch");

    // Reset during data bit 4 of 0x81; the line returns to idle with it
    drive(1'b0, DIV);
    for (int i = 0; i < 4; i++) drive(i == 0, DIV);
    drive(1'b0, DIV / 2);
    reset = 1'b1;
    io_rx = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_valid", io_out_valid, 1'b0);
    check("midreset_bits", io_out_bits, 8'h00);
    check("midreset_busy", io_busy, 1'b0);
    check("midreset_flags", {io_frame_err, io_overrun}, 2'b00);
    reset = 1'b0;
    drive(1'b1, 12 * DIV);
    check_flags("midreset_idle");
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    drive(1'b1, 2 * DIV);
    check_flags("midreset_clean");

    // Random frames, occasional bad stop bits, random idle gaps
    for (int n = 0; n < 24; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      if (!bad) exp_q.push_back(b);
      send_frame(b, !bad);
      if (bad) begin
        exp_ferr++;
        drive(1'b1, DIV);
      end else begin
        gap = $urandom_range(0, DIV);
        if (gap > 0) drive(1'b1, gap);
      end
    end
    drive(1'b1, 2 * DIV);
    check_flags("random");
    check("final_busy", io_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
